// File: rtl/imem_loader.sv
// Boot-time loader: receives a framed byte stream (count, payload, XOR checksum)
// and writes little-endian 32-bit words into imem from address 0, then releases the core.
//
// state | meaning
// HDR0  | waiting for word-count low byte
// HDR1  | waiting for word-count high byte; range check
// DATA  | assembling payload words and writing them to imem
// CSUM  | waiting for checksum byte
// RUN   | program verified, core released
// ERR   | frame rejected, core held off
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_run,
    output logic              busy,
    output logic              err
);

    typedef enum logic [2:0] {
        HDR0 = 3'd0,
        HDR1 = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        RUN  = 3'd4,
        ERR  = 3'd5
    } state_t;

    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

    state_t      state;
    state_t      nextState;
    logic [15:0] nCount;
    logic [15:0] wordCnt;
    logic [15:0] wordNext;
    logic [15:0] nFull;
    logic [1:0]  byteIdx;
    logic [23:0] wordBuf;
    logic [7:0]  xorAcc;
    logic        loading;
    logic        handshake;
    logic        restart;

    assign loading   = (state == HDR0) || (state == HDR1) || (state == DATA) || (state == CSUM);
    assign in_ready  = loading && rst_n;
    assign handshake = in_valid && in_ready;
    assign restart   = reload && ((state == RUN) || (state == ERR));
    assign wordNext  = wordCnt + 16'd1;
    assign nFull     = {in_data, nCount[7:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HDR0;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            HDR0: if (handshake) nextState = HDR1;
            HDR1: begin
                if (handshake) begin
                    if ({1'b0, nFull} > MAX_WORDS) begin
                        nextState = ERR;
                    end else if (nFull == 16'd0) begin
                        nextState = CSUM;
                    end else begin
                        nextState = DATA;
                    end
                end
            end
            DATA: if (handshake && (byteIdx == 2'd3) && (wordNext == nCount)) nextState = CSUM;
            CSUM: if (handshake) nextState = (in_data == xorAcc) ? RUN : ERR;
            RUN:  if (reload) nextState = HDR0;
            ERR:  if (reload) nextState = HDR0;
            default: nextState = HDR0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nCount     <= '0;
            wordCnt    <= '0;
            byteIdx    <= '0;
            wordBuf    <= '0;
            xorAcc     <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_run    <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            // HDR0 is only re-entered via reset or reload, so any later loading state implies a byte arrived
            busy    <= (nextState == HDR1) || (nextState == DATA) || (nextState == CSUM);
            cpu_run <= (nextState == RUN);
            err     <= (nextState == ERR);
            if (restart) begin
                nCount  <= '0;
                wordCnt <= '0;
                byteIdx <= '0;
                wordBuf <= '0;
                xorAcc  <= '0;
            end else if (handshake) begin
                if (state != CSUM) begin
                    xorAcc <= xorAcc ^ in_data;
                end
                case (state)
                    HDR0: nCount[7:0]  <= in_data;
                    HDR1: nCount[15:8] <= in_data;
                    DATA: begin
                        byteIdx <= byteIdx + 2'd1;
                        // shift right so the first byte of a word ends up in the low lane
                        wordBuf <= {in_data, wordBuf[23:8]};
                        if (byteIdx == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= wordCnt[ADDR_W-1:0];
                            imem_wdata <= {in_data, wordBuf};
                            wordCnt    <= wordNext;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that writes instruction words into the rv32i instruction memory, which the fetch path only reads. It accepts a framed byte stream (header, payload, checksum) over a valid/ready interface and assembles little-endian 32-bit words. Each word is written to consecutive imem word addresses starting at 0. When the frame verifies, the loader releases the core with `cpu_run`. It sits between the board byte source (UART receiver or testbench) and the imem write port, and holds the core off until a program is present.

## Interface
- `ADDR_W`, 8, imem word-address width; capacity MAX = 2^ADDR_W words.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  byte source has a byte.
- `in_data`  in  8  byte value.
- `in_ready`  out  1  loader accepts a byte this cycle; transfer when `in_valid & in_ready`.
- `reload`  in  1  synchronous, one-cycle request to restart loading; honoured only in RUN or ERR.
- `imem_we`  out  1  one-cycle imem write strobe.
- `imem_addr`  out  ADDR_W  word address of the write.
- `imem_wdata`  out  32  instruction word.
- `cpu_run`  out  1  high = core may leave reset and execute.
- `busy`  out  1  high in HDR0..CSUM after at least one byte has been accepted.
- `err`  out  1  frame rejected; sticky until reset or reload.

## Operation
- Frame format:
  - N_lo, N_hi: word count N, 16-bit, little-endian.
  - 4·N payload bytes, little-endian per word.
  - One checksum byte equal to the XOR of all header and payload bytes.
- States:
  - HDR0: accept N_lo → HDR1.
  - HDR1: accept N_hi. If N > MAX → ERR. If N == 0 → CSUM. Otherwise → DATA.
  - DATA: accept payload. The byte with index k in the current word goes to bits [8k+7:8k]. After the 4th byte of word j, write word j. After word N−1 → CSUM.
  - CSUM: accept one byte. Equal to the running XOR → RUN, otherwise → ERR.
  - RUN: `cpu_run`=1, `in_ready`=0. On `reload` → HDR0.
  - ERR: `err`=1, `in_ready`=0, `cpu_run`=0. On `reload` → HDR0.
- `in_ready` = 1 exactly in HDR0, HDR1, DATA and CSUM, and 0 while `rst_n` is low. It never depends on `in_valid`.
- Word counter j runs 0..N−1. N = MAX is legal; the last address is MAX−1 and the counter must not wrap into a further write.
- Reload clears j, the partial word, the XOR accumulator, `err` and `cpu_run`. Imem contents are not cleared.
- Bytes whose `in_valid` is low are ignored. Arbitrary gaps between bytes are allowed.

## Timing
- Reset (asynchronous, takes effect immediately):
  - Outputs: `in_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_run`=0, `busy`=0, `err`=0.
  - State → HDR0. Counters, partial word and XOR accumulator are cleared.
  - A partial word in progress is discarded and never written.
- After `rst_n` deasserts, `in_ready`=1 from the first clock edge onward.
- All outputs except `in_ready` are registered.
- Write timing: `imem_we` goes high for exactly one cycle, in the cycle after the handshake of a word's 4th byte. `imem_addr` and `imem_wdata` are valid in that same cycle. A new byte may be accepted in that same cycle; byte throughput is 1 per clock.
- The write of the last word and the first CSUM cycle may coincide.
- `cpu_run` and `err` rise in the cycle after the deciding handshake, i.e. the CSUM byte or N_hi.
- `reload` is sampled on a clock edge. The loader is in HDR0 with `in_ready`=1 in the next cycle. `cpu_run` and `err` drop in that same cycle.
- `reload` in HDR0..CSUM has no effect.

## Test plan
- Single word: 01 00 13 05 A0 00 B7 at 1 byte/clock → exactly one `imem_we` pulse with addr 0 and wdata 0x00A00513. `cpu_run`=1 from the cycle after the B7 handshake; `err`=0.
- Bad checksum: N=2 with two valid words and a checksum byte XORed with 0x01 → two writes at addr 0 then 1. Then `err`=1, `cpu_run`=0 and `in_ready`=0.
- Oversize: 01 01 (N=257, ADDR_W=8) → `err`=1 in the cycle after the 2nd byte, and no `imem_we` ever. N=256 instead → 256 writes ending at addr 255, and `cpu_run`=1 after a correct checksum.
- Empty program: 00 00 00 → no writes, `cpu_run`=1.
- Reset mid-word: assert `rst_n`=0 after 2 payload bytes → all outputs 0 immediately and no write occurs. Then the single-word frame above → addr 0 is written with 0x00A00513, so no stale bytes leak into the word.
- Gaps and reload:
  - Random `in_valid` gaps of 0–5 cycles → identical writes and checksum result.
  - `reload` pulse in RUN → `cpu_run`=0 next cycle, and a second frame loads correctly.
  - `reload` during DATA → ignored.
